// File: rtl/btn_cond_pkg.sv
// Shared definitions for the push-button conditioner: channel FSM states,
// 100 MHz default timing constants and the counter width helper.
package btn_cond_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    PRESSED    = 3'd2,
    HELD       = 3'd3,
    DB_RELEASE = 3'd4
  } btn_state_t;

  localparam int unsigned DEF_DB_CYCLES     = 1_000_000;   // 10 ms
  localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;  // 500 ms
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;  // 100 ms

  // One counter width covers every terminal value, so all counters share it.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_cond_ch.sv
// Single button channel: two-flop synchronizer, debounce/classify FSM and counters.
// Periodic auto-repeat in HELD is built only when BTN_AUTO_REPEAT_EN is defined.
module btn_cond_ch
  import btn_cond_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic pe,
  output logic ne,
  output logic long_p,
  output logic rpt
);

  localparam int unsigned CW = cnt_width(DB_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] rpt_cnt;
`endif

  logic          s1, s2;
  btn_state_t    state;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] hold_cnt;
  logic          was_held;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      db_cnt   <= '0;
      hold_cnt <= '0;
      was_held <= 1'b0;
      level    <= 1'b0;
      pe       <= 1'b0;
      ne       <= 1'b0;
      long_p   <= 1'b0;
      rpt      <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_cnt  <= '0;
`endif
    end else begin
      pe     <= 1'b0;
      ne     <= 1'b0;
      long_p <= 1'b0;
      rpt    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s2) begin
            state  <= DB_PRESS;
            db_cnt <= '0;
          end
        end
        DB_PRESS: begin
          if (!s2) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state    <= PRESSED;
            pe       <= 1'b1;
            rpt      <= 1'b1;
            level    <= 1'b1;
            hold_cnt <= '0;
            was_held <= 1'b0;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!s2) begin
            state  <= DB_RELEASE;
            db_cnt <= '0;
          end else if (hold_cnt == LONG_LAST) begin
            state    <= HELD;
            long_p   <= 1'b1;
            was_held <= 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_cnt  <= '0;
`endif
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        HELD: begin
          if (!s2) begin
            state  <= DB_RELEASE;
            db_cnt <= '0;
          end
`ifdef BTN_AUTO_REPEAT_EN
          else if (rpt_cnt == RPT_LAST) begin
            rpt     <= 1'b1;
            rpt_cnt <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + CW'(1);
          end
`endif
        end
        DB_RELEASE: begin
          // Bounce during release resumes the prior state with its counters intact.
          if (s2) begin
            state <= was_held ? HELD : PRESSED;
          end else if (db_cnt == DB_LAST) begin
            state <= IDLE;
            ne    <= 1'b1;
            level <= 1'b0;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: one independent btn_cond_ch per button.
// Define BTN_AUTO_REPEAT_EN to enable periodic btn_rpt pulses while a button is held.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pe,
  output logic [N_BTN-1:0] btn_ne,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_rpt
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_cond_ch #(
      .DB_CYCLES    (DB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (btn_raw[i]),
      .level  (btn_level[i]),
      .pe     (btn_pe[i]),
      .ne     (btn_ne[i]),
      .long_p (btn_long[i]),
      .rpt    (btn_rpt[i])
    );
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front end for all push-buttons feeding the multi-function clock: watch, stopwatch, cook timer and the mode selector.
- Per channel it synchronizes, debounces and classifies raw button inputs into clean level, press/release pulses, long-press and auto-repeat pulses.
- Its outputs are the one-cycle strobes that the mode router and the per-mode blocks consume.
- One instance replaces the scattered per-button edge detectors.

Parameters:
- N_BTN, 4, number of independent button channels.
- DB_CYCLES, 1_000_000, stable-input cycles needed to accept a press or release (10 ms at 100 MHz); minimum 2.
- LONG_CYCLES, 50_000_000, pressed cycles before a long-press is declared (500 ms); minimum 2.
- REPEAT_CYCLES, 10_000_000, period between auto-repeat pulses in the HELD state (100 ms); minimum 2.

Ports:
- clk  input  1  system clock (100 MHz).
- reset_n  input  1  asynchronous active-low reset.
- btn_raw  input  N_BTN  raw, asynchronous, bouncing button inputs (1 = pressed).
- btn_level  output  N_BTN  debounced button level.
- btn_pe  output  N_BTN  one-cycle pulse on an accepted press.
- btn_ne  output  N_BTN  one-cycle pulse on an accepted release.
- btn_long  output  N_BTN  one-cycle pulse when a press reaches LONG_CYCLES.
- btn_rpt  output  N_BTN  one-cycle pulse on press plus periodic repeats while held.

Behaviour:
- One clock domain; reset is asynchronous and active-low. All flops reset on reset_n=0.
- Reset values: every output 0, every FSM in IDLE, all counters 0, synchronizer flops 0.
- Channels are fully independent. Simultaneous events on different channels are handled in the same cycle with no priority.
- Synchronizer: two flops per bit (s1, s2). The FSM only ever sees s2.
- Per-channel FSM states: IDLE, DB_PRESS, PRESSED, HELD, DB_RELEASE.
  - IDLE: level=0. s2=1 -> DB_PRESS, db_cnt=0.
  - DB_PRESS: s2=0 -> IDLE, with no pulse (glitch rejected). Otherwise db_cnt++. When s2=1 with db_cnt==DB_CYCLES-1 -> PRESSED: btn_pe=1 and btn_rpt=1 for one cycle, level=1, hold_cnt=0.
  - PRESSED: s2=0 -> DB_RELEASE, db_cnt=0. Otherwise hold_cnt++. When hold_cnt==LONG_CYCLES-1 -> HELD: btn_long=1 for one cycle, rpt_cnt=0.
  - HELD: s2=0 -> DB_RELEASE, db_cnt=0. Otherwise rpt_cnt++. When rpt_cnt==REPEAT_CYCLES-1: btn_rpt=1 for one cycle, rpt_cnt=0.
  - DB_RELEASE: level stays 1; hold_cnt and rpt_cnt are frozen.
    - s2=1 -> return to the state it came from, PRESSED or HELD (tracked by a was_held flag), with no pulse (release bounce rejected).
    - s2=0 with db_cnt==DB_CYCLES-1 -> IDLE: btn_ne=1 for one cycle, level=0.
- Latency: if raw is sampled high at edge k and stays stable, btn_pe is registered high at edge k+DB_CYCLES+2. Release latency is identical.
- Counter width: clog2 of the largest cycle parameter. Counters never wrap past their terminal values.
- Output pulses are registered; at most one of btn_pe, btn_ne, btn_long per channel per cycle.
- Reset mid-press: all outputs drop immediately and no btn_ne is issued. If the button is still held after reset release, a fresh press is detected and btn_pe fires again.

Optional Feature:
- Macro BTN_AUTO_REPEAT_EN.
- Defined: HELD generates periodic btn_rpt pulses as above.
- Undefined: rpt_cnt is not built, HELD emits no repeats, and btn_rpt is identical to btn_pe. btn_long is unaffected in both cases.

Decomposition:
- Shared package btn_cond_pkg holds:
  - FSM state encoding localparams (IDLE=0 … DB_RELEASE=4, 3 bits);
  - default cycle constants for 100 MHz;
  - a function computing counter width.
- One sub-module, btn_cond_ch: a single channel containing synchronizer, FSM and counters. The top instantiates it N_BTN times via generate.

Test Plan (DB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, BTN_AUTO_REPEAT_EN defined):
- Assert reset_n=0 with btn_raw=4'hF -> all outputs 0. Release reset with btn_raw[0]=1 rising at edge 0 -> btn_pe[0] and btn_rpt[0] high for exactly one cycle after edge 6; btn_level[0]=1 from edge 6.
- btn_raw[1] high for 3 cycles then low -> btn_pe[1], btn_level[1] and btn_ne[1] stay 0 throughout.
- Hold btn_raw[2] for 60 cycles:
  - btn_long[2] pulses 20 cycles after btn_pe[2];
  - btn_rpt[2] pulses every 5 cycles after that;
  - btn_ne[2] pulses 6 cycles after raw falls.
- While btn_level[3]=1, inject 1-cycle and 3-cycle low blips on btn_raw[3] -> no btn_ne[3], no second btn_pe[3], level stays 1.
- Press btn_raw[0] and btn_raw[3] on the same edge -> both btn_pe bits assert in the same cycle.
- Pulse reset_n low while channel 2 is in HELD and btn_raw[2] is still high:
  - outputs clear immediately and no btn_ne[2] is issued;
  - a new btn_pe[2] fires DB_CYCLES+2 cycles after reset release.
